// File: rtl/jtag_dump_if.sv
// jtag_dump_if: start request, data/instruction memory read ports and the
// word-stream handshake of the memory dump engine; master is the dump engine.
interface jtag_dump_if #(
    parameter int AW = 9,
    parameter int DW = 32
);
    logic          i_start;
    logic          o_dmem_re;
    logic [AW-1:0] o_dmem_addr;
    logic [DW-1:0] i_dmem_rdata;
    logic          o_imem_re;
    logic [AW-1:0] o_imem_addr;
    logic [DW-1:0] i_imem_rdata;
    logic [DW-1:0] o_jout;
    logic          o_jvalid;
    logic          i_jready;
    logic          o_jlast;
    logic          o_busy;
    logic          o_done;

    modport master (
        input  i_start, i_dmem_rdata, i_imem_rdata, i_jready,
        output o_dmem_re, o_dmem_addr, o_imem_re, o_imem_addr,
        output o_jout, o_jvalid, o_jlast, o_busy, o_done
    );

    modport slave (
        output i_start, i_dmem_rdata, i_imem_rdata, i_jready,
        input  o_dmem_re, o_dmem_addr, o_imem_re, o_imem_addr,
        input  o_jout, o_jvalid, o_jlast, o_busy, o_done
    );
endinterface

// File: rtl/jtag_dump.sv
// jtag_dump: streams data memory then instruction memory, each from the top
// address down to 0, through a 2-entry buffer onto a valid/ready word stream.
module jtag_dump #(
    parameter int DEPTH = 512,
    parameter int AW    = 9,
    parameter int DW    = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    jtag_dump_if.master  bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DMEM  = 2'd1;
    localparam logic [1:0] S_IMEM  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;
    localparam logic [AW-1:0] TOP  = AW'(DEPTH - 1);

    logic [1:0]    r_state;
    logic [AW-1:0] r_addr;
    logic          r_infl;
    logic          r_infl_imem;
    logic          r_infl_last;
    logic [DW:0]   r_fifo [2];
    logic          r_wp;
    logic          r_rp;
    logic [1:0]    r_cnt;

    logic          w_pop;
    logic          w_rd;
    logic [DW-1:0] w_wdata;

    assign w_pop   = bus.o_jvalid & bus.i_jready;
    // A read is allowed only if its word is guaranteed a buffer slot on return.
    assign w_rd    = (r_state == S_DMEM || r_state == S_IMEM) &&
                     ((3'(r_cnt) + 3'(r_infl)) < (3'd2 + 3'(w_pop)));
    assign w_wdata = r_infl_imem ? bus.i_imem_rdata : bus.i_dmem_rdata;

    assign bus.o_dmem_re   = w_rd && r_state == S_DMEM;
    assign bus.o_imem_re   = w_rd && r_state == S_IMEM;
    assign bus.o_dmem_addr = r_addr;
    assign bus.o_imem_addr = r_addr;
    assign bus.o_jvalid    = r_cnt != 2'd0;
    assign bus.o_jout      = bus.o_jvalid ? r_fifo[r_rp][DW-1:0] : '0;
    assign bus.o_jlast     = bus.o_jvalid & r_fifo[r_rp][DW];
    assign bus.o_busy      = r_state != S_IDLE;
    assign bus.o_done      = r_state == S_DRAIN && r_cnt == 2'd0 && !r_infl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_infl      <= 1'b0;
            r_infl_imem <= 1'b0;
            r_infl_last <= 1'b0;
            r_fifo[0]   <= '0;
            r_fifo[1]   <= '0;
            r_wp        <= 1'b0;
            r_rp        <= 1'b0;
            r_cnt       <= 2'd0;
        end else begin
            r_infl      <= w_rd;
            r_infl_imem <= r_state == S_IMEM;
            r_infl_last <= r_state == S_IMEM && r_addr == '0;
            if (r_state == S_IDLE && bus.i_start) begin
                r_state <= S_DMEM;
                r_addr  <= TOP;
            end else if (w_rd) begin
                r_state <= r_addr != '0 ? r_state : (r_state == S_DMEM ? S_IMEM : S_DRAIN);
                r_addr  <= r_addr != '0 ? r_addr - 1'b1 : TOP;
            end else if (bus.o_done) begin
                r_state <= S_IDLE;
            end
            // Returning read data is written unconditionally; the issue rule keeps room.
            if (r_infl) begin
                r_fifo[r_wp] <= {r_infl_last, w_wdata};
                r_wp         <= ~r_wp;
            end
            if (w_pop)
                r_rp <= ~r_rp;
            r_cnt <= r_cnt + 2'(r_infl) - 2'(w_pop);
        end
    end
endmodule

// File: tb/tb_jtag_dump.sv
// tb_jtag_dump: scoreboard bench; expected words are queued at each start and a
// negedge monitor pops and compares on every Jvalid&Jready handshake.
module tb_jtag_dump;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0, e0 = 0, errors = 0, checks = 0, mode = 0;
    int nrecv = 0, nreads = 0, ndone = 0, done_rel = 0, fv_rel = 0;
    int n4 = 0, done4_rel = 0;
    bit restarted = 0, rst_done = 0;
    logic [32:0] q[$], q4[$];
    logic [32:0] exp_w, exp4, pw;
    logic pv = 1'b0, pr = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    jtag_dump_if #(.AW(9), .DW(32)) b();
    jtag_dump_if #(.AW(2), .DW(32)) c();

    jtag_dump #(.DEPTH(512), .AW(9), .DW(32)) dut  (.clk(clk), .rst_n(rst_n), .bus(b));
    jtag_dump #(.DEPTH(4),   .AW(2), .DW(32)) dut4 (.clk(clk), .rst_n(rst_n), .bus(c));

    // memories: dmem[i]=i, imem[i]=0x1000+i, one-cycle read latency
    always @(posedge clk) begin
        if (b.o_dmem_re) b.i_dmem_rdata <= 32'(b.o_dmem_addr);
        if (b.o_imem_re) b.i_imem_rdata <= 32'h1000 + 32'(b.o_imem_addr);
        if (c.o_dmem_re) c.i_dmem_rdata <= 32'(c.o_dmem_addr);
        if (c.o_imem_re) c.i_imem_rdata <= 32'h1000 + 32'(c.o_imem_addr);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) pv = 1'b0;
        else begin
            if (pv && !pr) chk("hold under backpressure", {b.o_jvalid, b.o_jlast, b.o_jout}, {1'b1, pw});
            chk("outstanding<=2", 64'(nreads - nrecv <= 2), 1);
            chk("re exclusive", 64'(b.o_dmem_re & b.o_imem_re), 0);
            if (mode == 1 && cyc - e0 + 1 == 12) begin
                chk("bp held word", b.o_jout, 32'h1FF);
                chk("bp reads issued", nreads, 2);
            end
            if (b.o_dmem_re || b.o_imem_re) nreads++;
            if (b.o_jvalid && fv_rel == 0) fv_rel = cyc - e0 + 1;
            if (b.o_jvalid && b.i_jready) begin
                chk("word available", 64'(q.size() != 0), 1);
                if (q.size() != 0) begin
                    exp_w = q.pop_front();
                    chk("word", {b.o_jlast, b.o_jout}, exp_w);
                end
                nrecv++;
            end
            if (b.o_done) begin
                ndone++;
                done_rel = cyc - e0 + 1;
            end
            pv = b.o_jvalid;
            pr = b.i_jready;
            pw = {b.o_jlast, b.o_jout};
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (c.o_jvalid && c.i_jready) begin
                chk("d4 word available", 64'(q4.size() != 0), 1);
                if (q4.size() != 0) begin
                    exp4 = q4.pop_front();
                    chk("d4 word", {c.o_jlast, c.o_jout}, exp4);
                end
                n4++;
            end
            if (c.o_done) done4_rel = cyc - e0 + 1;
        end
    end

    // Jready pattern, start re-pulse and mid-dump reset per scenario mode
    initial forever begin
        @(posedge clk);
        #1;
        b.i_jready = mode == 1 ? !((cyc - e0 + 1) >= 3 && (cyc - e0 + 1) <= 12) :
                     mode == 2 ? 1'($urandom_range(0, 1)) : 1'b1;
        if (mode == 3 && nrecv >= 100) begin
            b.i_start = !restarted;
            restarted = 1;
        end
        if (mode == 4 && nrecv >= 300 && !rst_done) begin
            rst_n = 1'b0;
            rst_done = 1;
            #1;
            chk("outputs in mid-dump reset",
                {b.o_busy, b.o_done, b.o_jvalid, b.o_jlast, b.o_dmem_re, b.o_imem_re, b.o_jout}, 0);
            @(posedge clk);
            #1 rst_n = 1'b1;
        end
    end

    task automatic run(input int m);
        q.delete();
        for (int i = 511; i >= 0; i--) q.push_back({1'b0, 32'(i)});
        for (int i = 511; i >= 0; i--) q.push_back({i == 0, 32'h1000 + 32'(i)});
        nrecv = 0; nreads = 0; ndone = 0; done_rel = 0; fv_rel = 0;
        restarted = 0; rst_done = 0;
        @(posedge clk);
        #1 b.i_start = 1'b1;
        mode = m;
        @(posedge clk);
        #1 b.i_start = 1'b0;
        e0 = cyc;
        for (int i = 0; i < 6000 && ndone == 0 && !(m == 4 && rst_done); i++) @(posedge clk);
        if (m == 4) begin
            repeat (1100) @(posedge clk);
            chk("no done after reset", ndone, 0);
            chk("words before reset", nrecv, 300);
        end else begin
            repeat (5) @(posedge clk);
            chk("single done", ndone, 1);
            chk("word count", nrecv, 1024);
            chk("queue drained", q.size(), 0);
            if (m == 0) begin
                chk("first Jvalid cycle", fv_rel, 3);
                chk("done cycle", done_rel, 1027);
            end
        end
        mode = 0;
    endtask

    initial begin
        b.i_start = 1'b0;
        c.i_start = 1'b0;
        c.i_jready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("outputs in reset",
            {b.o_busy, b.o_done, b.o_jvalid, b.o_jlast, b.o_dmem_re, b.o_imem_re, b.o_jout}, 0);
        rst_n = 1'b1;
        run(0);
        run(1);
        run(2);
        run(3);
        run(4);
        run(0);
        q4.delete();
        for (int i = 3; i >= 0; i--) q4.push_back({1'b0, 32'(i)});
        for (int i = 3; i >= 0; i--) q4.push_back({i == 0, 32'h1000 + 32'(i)});
        n4 = 0;
        done4_rel = 0;
        @(posedge clk);
        #1 c.i_start = 1'b1;
        @(posedge clk);
        #1 c.i_start = 1'b0;
        e0 = cyc;
        repeat (30) @(posedge clk);
        chk("d4 done cycle", done4_rel, 11);
        chk("d4 word count", n4, 8);
        chk("d4 queue drained", q4.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/jtag_dump.md
JTAG_DUMP -- requirements
Module: jtag_dump

Interface
REQ-001 SHALL have parameter DEPTH, default 512, words per memory (both data and instruction memory).
REQ-002 SHALL have parameter AW, default 9, memory address width; DEPTH = 2**AW.
REQ-003 SHALL have parameter DW, default 32, word width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  single-cycle dump request.
REQ-007 SHALL have port dmem_re  output  1  data-memory read enable.
REQ-008 SHALL have port dmem_addr  output  AW  data-memory read address.
REQ-009 SHALL have port dmem_rdata  input  DW  data-memory read data; valid in the cycle after dmem_re.
REQ-010 SHALL have port imem_re  output  1  instruction-memory read enable.
REQ-011 SHALL have port imem_addr  output  AW  instruction-memory read address.
REQ-012 SHALL have port imem_rdata  input  DW  instruction-memory read data; valid in the cycle after imem_re.
REQ-013 SHALL have port Jout  output  DW  serial-stream word; it is the buffer head.
REQ-014 SHALL have port Jvalid  output  1  Jout holds a word.
REQ-015 SHALL have port Jready  input  1  consumer accepts Jout this cycle.
REQ-016 SHALL have port Jlast  output  1  Jout is the final word of the dump.
REQ-017 SHALL have port busy  output  1  dump in progress.
REQ-018 SHALL have port done  output  1  one-cycle pulse when the dump completes.

Function
REQ-019 SHALL stream memory contents in loader order: data memory at addresses DEPTH-1 down to 0, then instruction memory at addresses DEPTH-1 down to 0, for 2*DEPTH words total.
REQ-020 SHALL implement a state machine with states IDLE, DMEM, IMEM and DRAIN.
REQ-021 SHALL move IDLE->DMEM when start=1 and load the read address counter with DEPTH-1.
REQ-022 SHALL move DMEM->IMEM when the dmem read at address 0 issues, and reload the counter with DEPTH-1.
REQ-023 SHALL move IMEM->DRAIN when the imem read at address 0 issues.
REQ-024 SHALL move DRAIN->IDLE once the buffer is empty and no read is in flight, pulsing done=1 for that one cycle.
REQ-025 SHALL ignore start whenever busy=1; there is no queuing and no restart.
REQ-026 SHALL drive busy=1 in DMEM, IMEM and DRAIN.
REQ-027 SHALL drive *_re for one cycle per read; *_addr is don't-care when *_re=0; dmem_re and imem_re are never both 1.
REQ-028 SHALL hold read data in a 2-entry FIFO: write on the cycle the read data returns, pop on Jvalid&Jready.
REQ-029 SHALL drive Jvalid = (FIFO count != 0).
REQ-030 SHALL issue a read only when count + inflight - pop < 2, so reads issue every cycle under Jready=1 and the FIFO never overflows.
REQ-031 SHALL hold Jout/Jvalid/Jlast stable while Jvalid=1 and Jready=0.
REQ-032 SHALL set Jlast=1 exactly when the head entry is imem address 0, carried as a tag bit in the FIFO.
REQ-033 SHALL achieve latency from the start-sampling edge E0 of re at cycle 1, Jvalid at cycle 3, and first word = dmem[DEPTH-1].
REQ-034 SHALL achieve throughput of 1 word/cycle with Jready held at 1; the final handshake occurs in cycle 2*DEPTH+2 and done in the next cycle.
REQ-035 SHALL, when a pop and a write occur in the same cycle, perform both and leave count unchanged.
REQ-036 SHALL drop a start coincident with the done cycle; a new dump needs start while in IDLE.

Reset
REQ-037 SHALL, with rst=0 asynchronously, force state=IDLE, clear the FIFO and inflight, and set the counter to 0.
REQ-038 SHALL, while rst=0, hold busy, done, Jvalid, Jlast, dmem_re and imem_re at 0 and Jout at 0.
REQ-039 SHALL abort a dump in progress when rst is asserted mid-dump, with no done pulse; a later start restarts from dmem[DEPTH-1].

Verification
REQ-040 SHALL cover: dmem[i]=i, imem[i]=32'h1000+i, Jready=1, start pulse -> 1024 words 0x1FF..0x000, then 0x11FF..0x1000, no gaps, Jlast only on 0x1000, done one cycle later.
REQ-041 SHALL cover: Jready=0 from cycle 3 for 10 cycles -> Jout=0x1FF held, at most 2 reads issued in total, then the stream resumes with 0x1FE and no word lost or duplicated.
REQ-042 SHALL cover: Jready random at 50% -> received sequence identical to the first scenario, FIFO count never exceeds 2.
REQ-043 SHALL cover: start re-pulsed at word 100 -> ignored, total still 1024 words, a single done.
REQ-044 SHALL cover: rst=0 at word 300 for 1 cycle -> all outputs 0 immediately, no done; a new start yields first word 0x1FF.
REQ-045 SHALL cover: DEPTH=4 -> words dmem[3..0] then imem[3..0], done in cycle 11 after start with Jready=1.
